// File: rtl/wave_capture.sv
// Zero-crossing triggered capture of an 18-bit sample stream into a double-buffered
// 2 x 2**DEPTH_LOG2 x 8 RAM, handed to the wave display when it reports idle.
module wave_capture #(
  parameter int SAMPLE_WIDTH = 18,
  parameter int DEPTH_LOG2   = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  input  logic [DEPTH_LOG2-1:0]   read_address,
  output logic [7:0]              read_sample,
  output logic                    read_index,
  output logic                    capture_done,
  output logic [1:0]              state
);

  localparam int                    TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [DEPTH_LOG2-1:0] ADDR_LAST    = '1;
  localparam int                    RAM_WORDS    = 2 ** (DEPTH_LOG2 + 1);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_WAIT   = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic                  write_bank_q, write_bank_d;
  logic [DEPTH_LOG2-1:0] write_addr_q, write_addr_d;
  logic [TW-1:0]         timeout_cnt_q, timeout_cnt_d;
  logic                  prev_neg_q, prev_neg_d;
  logic [7:0]            read_sample_q;

  logic [7:0]            mem [0:RAM_WORDS-1];
  logic                  we;
  logic [DEPTH_LOG2:0]   waddr;
  logic [7:0]            wdata;
  logic                  sample_neg;
  logic                  crossing;

  assign sample_neg = new_sample_in[SAMPLE_WIDTH-1];
  assign crossing   = new_sample_ready && prev_neg_q && !sample_neg;
  // Top 8 bits with the sign flipped: signed sample -> offset-binary display byte.
  assign wdata      = {~new_sample_in[SAMPLE_WIDTH-1], new_sample_in[SAMPLE_WIDTH-2 -: 7]};

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    write_bank_d  = write_bank_q;
    write_addr_d  = write_addr_q;
    timeout_cnt_d = timeout_cnt_q;
    prev_neg_d    = new_sample_ready ? sample_neg : prev_neg_q;
    we            = 1'b0;
    waddr         = {write_bank_q, write_addr_q};
    capture_done  = 1'b0;

    unique case (state_q)
      ST_ARMED: begin
        if (new_sample_ready) begin
          if (crossing || (timeout_cnt_q == TIMEOUT_LAST)) begin
            we            = 1'b1;
            waddr         = {write_bank_q, {DEPTH_LOG2{1'b0}}};
            write_addr_d  = DEPTH_LOG2'(1);
            timeout_cnt_d = '0;
            state_d       = ST_ACTIVE;
          end else begin
            timeout_cnt_d = timeout_cnt_q + TW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (new_sample_ready) begin
          we           = 1'b1;
          write_addr_d = write_addr_q + DEPTH_LOG2'(1);
          if (write_addr_q == ADDR_LAST) begin
            capture_done = 1'b1;
            state_d      = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Swap only while the display is not drawing, so it never sees a torn bank.
        if (wave_display_idle) begin
          write_bank_d = ~write_bank_q;
          state_d      = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_ARMED;
      write_bank_q  <= 1'b0;
      write_addr_q  <= '0;
      timeout_cnt_q <= '0;
      prev_neg_q    <= 1'b0;
      read_sample_q <= '0;
    end else begin
      state_q       <= state_d;
      write_bank_q  <= write_bank_d;
      write_addr_q  <= write_addr_d;
      timeout_cnt_q <= timeout_cnt_d;
      prev_neg_q    <= prev_neg_d;
      read_sample_q <= mem[{~write_bank_q, read_address}];
    end
  end

  // NOTE: the RAM array has no reset so it can map onto a block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign read_sample = read_sample_q;
  assign read_index  = ~write_bank_q;
  assign state       = state_q;

endmodule
